// File: rtl/conv_mem_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// conv_mem_write_ctrl_if
// Bus between a convolution datapath controller (master) and the output-RAM
// write sequencer (slave).
//   start     master->slave  begin a pass (honoured only when idle or done)
//   enable    master->slave  advance qualifier, low = stall
//   addr0     slave->master  pixel address within current channel
//   channel   slave->master  current channel index
//   flat_addr slave->master  channel*IMG_W*IMG_H + addr0
//   we        slave->master  one-cycle write strobe per pixel
//   busy      slave->master  pass in progress (DELAY or RUN)
//   done      slave->master  pass finished, held until next start or reset
// ---------------------------------------------------------------------------
interface conv_mem_write_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int CH_W   = 2,
  parameter int FLAT_W = 8
);
  logic              start;
  logic              enable;
  logic [ADDR_W-1:0] addr0;
  logic [CH_W-1:0]   channel;
  logic [FLAT_W-1:0] flat_addr;
  logic              we;
  logic              busy;
  logic              done;

  modport master (
    output start, enable,
    input  addr0, channel, flat_addr, we, busy, done
  );

  modport slave (
    input  start, enable,
    output addr0, channel, flat_addr, we, busy, done
  );
endinterface

// File: rtl/conv_mem_write_ctrl.sv
// ---------------------------------------------------------------------------
// conv_mem_write_ctrl
// Write-address sequencer for a convolution layer's output memory. Walks an
// IMG_W x IMG_H image once per channel, holding each pixel address for
// CYCLES_PER_PIX enabled cycles and strobing we in the pixel's last cycle.
// An optional START_DELAY phase precedes the first pixel.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    slave side of conv_mem_write_ctrl_if (start/enable in;
//          addr0/channel/flat_addr/we/busy/done out)
// ---------------------------------------------------------------------------
module conv_mem_write_ctrl #(
  parameter int IMG_W          = 8,
  parameter int IMG_H          = 8,
  parameter int CHANNELS       = 3,
  parameter int CYCLES_PER_PIX = 25,
  parameter int START_DELAY    = 1,
  parameter int ADDR_W = (IMG_W*IMG_H > 1) ? $clog2(IMG_W*IMG_H) : 1,
  parameter int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int FLAT_W = (IMG_W*IMG_H*CHANNELS > 1) ? $clog2(IMG_W*IMG_H*CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_mem_write_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int PIX   = IMG_W * IMG_H;
  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int CYC_W = (CYCLES_PER_PIX > 1) ? $clog2(CYCLES_PER_PIX) : 1;

  localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(CYCLES_PER_PIX - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIX - 1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CHANNELS - 1);

  // With no delay phase a start goes straight to the first pixel.
  localparam state_t FIRST_STATE = (START_DELAY == 0) ? S_RUN : S_DELAY;

  state_t              r_state, w_state_nxt;
  logic [DLY_W-1:0]    r_dly,   w_dly_nxt;
  logic [CYC_W-1:0]    r_cyc,   w_cyc_nxt;
  logic [ADDR_W-1:0]   r_addr0, w_addr0_nxt;
  logic [CH_W-1:0]     r_chan,  w_chan_nxt;
  logic [FLAT_W-1:0]   r_flat,  w_flat_nxt;
  logic                w_we;

  // Write strobe in the pixel's last enabled cycle; the registered address
  // shown in that same cycle is the write target.
  assign w_we = (r_state == S_RUN) && bus.enable && (r_cyc == CYC_LAST);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch); the branches below only override.
    w_state_nxt = r_state;
    w_dly_nxt   = r_dly;
    w_cyc_nxt   = r_cyc;
    w_addr0_nxt = r_addr0;
    w_chan_nxt  = r_chan;
    w_flat_nxt  = r_flat;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt = FIRST_STATE;
          w_dly_nxt   = '0;
          w_cyc_nxt   = '0;
          w_addr0_nxt = '0;
          w_chan_nxt  = '0;
          w_flat_nxt  = '0;
        end
      end

      S_DELAY: begin
        if (bus.enable) begin
          if (r_dly == DLY_LAST) begin
            w_dly_nxt   = '0;
            w_state_nxt = S_RUN;
          end else begin
            w_dly_nxt = r_dly + DLY_W'(1);
          end
        end
      end

      S_RUN: begin
        if (bus.enable) begin
          if (w_we) begin
            w_cyc_nxt = '0;
            if (r_addr0 != PIX_LAST) begin
              w_addr0_nxt = r_addr0 + ADDR_W'(1);
              w_flat_nxt  = r_flat + FLAT_W'(1);
            end else if (r_chan != CH_LAST) begin
              w_addr0_nxt = '0;
              w_chan_nxt  = r_chan + CH_W'(1);
              w_flat_nxt  = r_flat + FLAT_W'(1);
            end else begin
              // Final pixel written: addresses hold their last values.
              w_state_nxt = S_DONE;
            end
          end else begin
            w_cyc_nxt = r_cyc + CYC_W'(1);
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_state <= S_IDLE;
      r_dly   <= '0;
      r_cyc   <= '0;
      r_addr0 <= '0;
      r_chan  <= '0;
      r_flat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dly   <= w_dly_nxt;
      r_cyc   <= w_cyc_nxt;
      r_addr0 <= w_addr0_nxt;
      r_chan  <= w_chan_nxt;
      r_flat  <= w_flat_nxt;
    end
  end

  assign bus.addr0     = r_addr0;
  assign bus.channel   = r_chan;
  assign bus.flat_addr = r_flat;
  assign bus.we        = w_we;
  assign bus.busy      = (r_state == S_DELAY) || (r_state == S_RUN);
  assign bus.done      = (r_state == S_DONE);

endmodule

// File: tb/tb_conv_mem_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_mem_write_ctrl
// Three instances: A = defaults (8x8x3, 25 cycles/pixel, delay 1),
// B = 4x4x2, 1 cycle/pixel, no delay, C = 1x1x1, 3 cycles/pixel, delay 2.
// For every accepted start the expected write list of a whole pass is queued:
// pixel f goes to addr0 = f % (W*H), channel = f / (W*H), and its strobe
// lands on enabled cycle START_DELAY + (f+1)*CYCLES_PER_PIX after the start.
// The monitor counts enabled cycles per instance and pops on every strobe.
// ---------------------------------------------------------------------------
module tb_conv_mem_write_ctrl;

  typedef struct {
    int  flat;
    int  addr0;
    int  ch;
    int  en_cyc;
    bit  last;
  } exp_t;

  // Per-instance geometry: {pixels per channel, channels, cycles/pixel, delay}
  int cfg_pix [3] = '{64, 16, 1};
  int cfg_ch  [3] = '{3, 2, 1};
  int cfg_cpp [3] = '{25, 1, 3};
  int cfg_dly [3] = '{1, 0, 2};

  logic clk;
  logic rst_a, rst_b, rst_c;

  conv_mem_write_ctrl_if #(.ADDR_W(6), .CH_W(2), .FLAT_W(8)) a_if ();
  conv_mem_write_ctrl_if #(.ADDR_W(4), .CH_W(1), .FLAT_W(5)) b_if ();
  conv_mem_write_ctrl_if #(.ADDR_W(1), .CH_W(1), .FLAT_W(1)) c_if ();

  conv_mem_write_ctrl dut_a (.clk(clk), .reset(rst_a), .bus(a_if.slave));

  conv_mem_write_ctrl #(
    .IMG_W(4), .IMG_H(4), .CHANNELS(2), .CYCLES_PER_PIX(1), .START_DELAY(0)
  ) dut_b (.clk(clk), .reset(rst_b), .bus(b_if.slave));

  conv_mem_write_ctrl #(
    .IMG_W(1), .IMG_H(1), .CHANNELS(1), .CYCLES_PER_PIX(3), .START_DELAY(2)
  ) dut_c (.clk(clk), .reset(rst_c), .bus(c_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  exp_t sb_q [3][$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- per-instance accessors ---------------------------------------------
  task automatic set_start(input int d, input logic v);
    case (d)
      0: a_if.start = v;
      1: b_if.start = v;
      default: c_if.start = v;
    endcase
  endtask

  task automatic set_en(input int d, input logic v);
    case (d)
      0: a_if.enable = v;
      1: b_if.enable = v;
      default: c_if.enable = v;
    endcase
  endtask

  function automatic bit done_of(input int d);
    case (d)
      0: return a_if.done;
      1: return b_if.done;
      default: return c_if.done;
    endcase
  endfunction

  // Reference model: the full write list of one pass.
  task automatic push_pass(input int d);
    int n;
    exp_t e;
    n = cfg_pix[d] * cfg_ch[d];
    for (int f = 0; f < n; f++) begin
      e.flat   = f;
      e.addr0  = f % cfg_pix[d];
      e.ch     = f / cfg_pix[d];
      e.en_cyc = cfg_dly[d] + (f + 1) * cfg_cpp[d];
      e.last   = (f == n - 1);
      sb_q[d].push_back(e);
    end
  endtask

  // Pulse start for one cycle with enable high; optionally queue a pass.
  task automatic pulse_start(input int d, input bit expect_accept);
    @(posedge clk); #1;
    set_start(d, 1'b1);
    set_en(d, 1'b1);
    if (expect_accept) push_pass(d);
    @(posedge clk); #1;
    set_start(d, 1'b0);
  endtask

  task automatic run_to_done(input int d, input bit rnd, input int budget);
    int n;
    n = 0;
    while (!done_of(d) && n < budget) begin
      @(posedge clk); #1;
      set_en(d, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    set_en(d, 1'b1);
    check($sformatf("d%0d_done_within_budget", d), int'(done_of(d)), 1);
    check($sformatf("d%0d_queue_drained", d), sb_q[d].size(), 0);
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_addr0"}, int'(a_if.addr0), 0);
    check({tag, "_channel"}, int'(a_if.channel), 0);
    check({tag, "_flat"}, int'(a_if.flat_addr), 0);
    check({tag, "_we"}, int'(a_if.we), 0);
    check({tag, "_busy"}, int'(a_if.busy), 0);
    check({tag, "_done"}, int'(a_if.done), 0);
  endtask

  // ---- monitor ------------------------------------------------------------
  int  en_cnt   [3];
  bit  active   [3];
  bit  exp_done [3];

  always @(negedge clk) begin
    logic m_rst [3];
    logic m_start [3], m_en [3], m_we [3], m_busy [3], m_done [3];
    int   m_addr [3], m_ch [3], m_flat [3];
    exp_t e;

    m_rst   = '{rst_a, rst_b, rst_c};
    m_start = '{a_if.start, b_if.start, c_if.start};
    m_en    = '{a_if.enable, b_if.enable, c_if.enable};
    m_we    = '{a_if.we, b_if.we, c_if.we};
    m_busy  = '{a_if.busy, b_if.busy, c_if.busy};
    m_done  = '{a_if.done, b_if.done, c_if.done};
    m_addr  = '{int'(a_if.addr0), int'(b_if.addr0), int'(c_if.addr0)};
    m_ch    = '{int'(a_if.channel), int'(b_if.channel), int'(c_if.channel)};
    m_flat  = '{int'(a_if.flat_addr), int'(b_if.flat_addr), int'(c_if.flat_addr)};

    for (int d = 0; d < 3; d++) begin
      if (m_rst[d] === 1'b1) begin
        active[d]   = 1'b0;
        exp_done[d] = 1'b0;
        continue;
      end
      if (exp_done[d]) begin
        check($sformatf("d%0d_done_after_last_we", d), int'(m_done[d]), 1);
        check($sformatf("d%0d_busy_after_last_we", d), int'(m_busy[d]), 0);
        exp_done[d] = 1'b0;
      end
      if (m_start[d] === 1'b1 && m_busy[d] === 1'b0) begin
        active[d] = 1'b1;
        en_cnt[d] = 0;
      end else if (active[d] && m_en[d] === 1'b1) begin
        en_cnt[d]++;
      end
      if (m_we[d] === 1'b1) begin
        if (sb_q[d].size() == 0) begin
          check($sformatf("d%0d_unexpected_we", d), 1, 0);
        end else begin
          e = sb_q[d].pop_front();
          check($sformatf("d%0d_flat[%0d]", d, e.flat), m_flat[d], e.flat);
          check($sformatf("d%0d_addr0[%0d]", d, e.flat), m_addr[d], e.addr0);
          check($sformatf("d%0d_channel[%0d]", d, e.flat), m_ch[d], e.ch);
          check($sformatf("d%0d_en_cycle[%0d]", d, e.flat), en_cnt[d], e.en_cyc);
          if (e.last) exp_done[d] = 1'b1;
        end
      end
    end
  end

  // ---- stimulus -----------------------------------------------------------
  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    for (int d = 0; d < 3; d++) begin
      set_start(d, 1'b0);
      set_en(d, 1'b1);
      active[d]   = 1'b0;
      exp_done[d] = 1'b0;
      en_cnt[d]   = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_a_zero("a_reset");

    // Reset and start together: reset wins.
    a_if.start = 1'b1;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    check_a_zero("a_reset_vs_start");
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(posedge clk); #1;
    check_a_zero("a_idle");

    // Small configurations: back-to-back writes, and single-pixel image.
    pulse_start(1, 1'b1);
    run_to_done(1, 1'b0, 100);
    pulse_start(2, 1'b1);
    run_to_done(2, 1'b0, 100);

    // Default pass with enable held high.
    pulse_start(0, 1'b1);
    check("a_busy_after_start", int'(a_if.busy), 1);
    run_to_done(0, 1'b0, 6000);

    // Restart from DONE: done drops, identical pass repeats.
    pulse_start(0, 1'b1);
    check("a_done_cleared_by_restart", int'(a_if.done), 0);
    check("a_busy_on_restart", int'(a_if.busy), 1);
    run_to_done(0, 1'b0, 6000);

    // Randomly stalled pass.
    pulse_start(0, 1'b1);
    run_to_done(0, 1'b1, 20000);

    // Start re-pulsed mid-pass is ignored.
    pulse_start(0, 1'b1);
    repeat (500) @(posedge clk);
    pulse_start(0, 1'b0);
    run_to_done(0, 1'b0, 6000);

    // Reset after 1000 RUN cycles, then a clean pass.
    pulse_start(0, 1'b1);
    repeat (1001) @(posedge clk);
    #1;
    check("a_busy_before_abort", int'(a_if.busy), 1);
    rst_a = 1'b1;
    sb_q[0].delete();
    @(posedge clk); #1;
    rst_a = 1'b0;
    check_a_zero("a_abort");
    repeat (40) @(posedge clk);
    #1;
    check("a_idle_after_abort_busy", int'(a_if.busy), 0);
    pulse_start(0, 1'b1);
    run_to_done(0, 1'b0, 6000);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
